// File: rtl/clk_gate_ctrl_pkg.sv
// Shared definitions for the clock-gate enable controller: state encoding,
// default parameter values and small helpers used by the top and the counter.
package clk_gate_ctrl_pkg;

   // Controller states; the encoding is fixed so software/debug views stay stable
   typedef enum logic [2:0] {
      RUN      = 3'd0,
      IDLE_CNT = 3'd1,
      STOP_REQ = 3'd2,
      GATED    = 3'd3,
      WAKE     = 3'd4
   } state_t;

   // Default idle counter width and handshake timing
   localparam int DEF_CNT_W    = 8;
   localparam int DEF_ACK_TO   = 16;
   localparam int DEF_WAKE_CYC = 4;

   // Width of the gated-cycle statistic counter
   localparam int STAT_W = 32;

   // Any of these conditions means the peripheral must keep its clock
   function automatic logic calc_inhibit(input logic busy,
                                         input logic wake_req,
                                         input logic sw_force_on,
                                         input logic sw_gate_en,
                                         input logic thresh_zero);
      return busy | wake_req | sw_force_on | ~sw_gate_en | thresh_zero;
   endfunction

   // Bits needed to hold values 0..max_val, never less than one bit
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/clk_gate_ctrl_cnt.sv
// Loadable saturating up-counter with a terminal-match flag. The controller
// uses three of these: idle interval, stop-acknowledge timeout and wake settle.
// SAT_HIT makes the all-ones value count as a match too, so a counter whose
// match value was moved below the current count still terminates.
module clk_gate_ctrl_cnt
   import clk_gate_ctrl_pkg::*;
#(
   parameter int W       = DEF_CNT_W,
   parameter bit SAT_HIT = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic [W-1:0] match_val,
   output logic         hit
);

   logic [W-1:0] count;

   // Load has priority over increment; the count holds once it reaches all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

   // Terminal flag is a live compare so a changing match value takes effect at once
   always_comb begin
      hit = (count == match_val) || (SAT_HIT && (count == '1));
   end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable-side controller for one gated-clock cell. Watches the peripheral's
// busy flag, asks it to stop after a programmable idle interval, drops
// module_en once it acknowledges, and reopens the clock on wake or software
// force with a settle window before ready is raised again.
// Optional gated-cycle statistics are built when CLK_GATE_CTRL_STAT_EN is defined.
module clk_gate_ctrl
   import clk_gate_ctrl_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int ACK_TO   = DEF_ACK_TO,
   parameter int WAKE_CYC = DEF_WAKE_CYC
) (
   input  logic             clk_in,
   input  logic             rst,
`ifdef CLK_GATE_CTRL_STAT_EN
   input  logic             stat_clr,
   output logic [STAT_W-1:0] gated_cycles,
`endif
   input  logic             busy,
   input  logic             wake_req,
   input  logic             stop_ack,
   input  logic             sw_force_on,
   input  logic             sw_gate_en,
   input  logic [CNT_W-1:0] idle_thresh,
   output logic             module_en,
   output logic             global_en,
   output logic             stop_req,
   output logic             ready,
   output logic             ack_err
);

   localparam int TO_W = cnt_width(ACK_TO);
   localparam int WK_W = cnt_width(WAKE_CYC);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TO - 1);
   localparam logic [WK_W-1:0] WK_LAST = WK_W'(WAKE_CYC - 1);

   state_t state;

   logic inhibit;
   logic abort;
   logic wake_cond;

   logic             idle_load;
   logic [CNT_W-1:0] idle_load_val;
   logic             idle_inc;
   logic             idle_hit;

   logic to_load;
   logic to_inc;
   logic to_hit;

   logic wk_load;
   logic wk_inc;
   logic wk_hit;

   // Input qualifiers shared by the FSM and the counter controls
   always_comb begin
      inhibit   = calc_inhibit(busy, wake_req, sw_force_on, sw_gate_en,
                               (idle_thresh == '0));
      abort     = busy | wake_req | sw_force_on;
      wake_cond = wake_req | sw_force_on | ~sw_gate_en;
   end

   // Idle counter: primed to 1 on the first idle cycle in RUN, counts while
   // idle in IDLE_CNT, and is held at zero everywhere else
   always_comb begin
      idle_load     = 1'b1;
      idle_load_val = '0;
      idle_inc      = 1'b0;
      case (state)
         RUN: begin
            if (!inhibit) begin
               idle_load_val = CNT_W'(1);
            end
         end
         IDLE_CNT: begin
            if (!inhibit && !idle_hit) begin
               idle_load = 1'b0;
               idle_inc  = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Timeout and wake counters advance only while their state is waiting,
   // and sit cleared otherwise so they start from zero on entry
   always_comb begin
      to_inc  = (state == STOP_REQ) && !abort && !stop_ack && !to_hit;
      to_load = !to_inc;
      wk_inc  = (state == WAKE) && !wk_hit;
      wk_load = !wk_inc;
   end

   clk_gate_ctrl_cnt #(
      .W       (CNT_W),
      .SAT_HIT (1'b1)
   ) u_idle_cnt (
      .clk       (clk_in),
      .rst       (rst),
      .load      (idle_load),
      .load_val  (idle_load_val),
      .inc       (idle_inc),
      .match_val (idle_thresh),
      .hit       (idle_hit)
   );

   clk_gate_ctrl_cnt #(
      .W       (TO_W),
      .SAT_HIT (1'b0)
   ) u_to_cnt (
      .clk       (clk_in),
      .rst       (rst),
      .load      (to_load),
      .load_val  ('0),
      .inc       (to_inc),
      .match_val (TO_LAST),
      .hit       (to_hit)
   );

   clk_gate_ctrl_cnt #(
      .W       (WK_W),
      .SAT_HIT (1'b0)
   ) u_wk_cnt (
      .clk       (clk_in),
      .rst       (rst),
      .load      (wk_load),
      .load_val  ('0),
      .inc       (wk_inc),
      .match_val (WK_LAST),
      .hit       (wk_hit)
   );

   // Gating FSM; every output is registered alongside the state it belongs to
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= RUN;
         module_en <= 1'b1;
         global_en <= 1'b1;
         stop_req  <= 1'b0;
         ready     <= 1'b1;
         ack_err   <= 1'b0;
      end else begin
         ack_err <= 1'b0;
         case (state)
            RUN: begin
               if (!inhibit) begin
                  state <= IDLE_CNT;
               end
            end
            IDLE_CNT: begin
               if (inhibit) begin
                  state <= RUN;
               end else if (idle_hit) begin
                  state    <= STOP_REQ;
                  stop_req <= 1'b1;
               end
            end
            STOP_REQ: begin
               if (abort) begin
                  state    <= RUN;
                  stop_req <= 1'b0;
               end else if (stop_ack) begin
                  state     <= GATED;
                  stop_req  <= 1'b0;
                  module_en <= 1'b0;
                  global_en <= 1'b0;
                  ready     <= 1'b0;
               end else if (to_hit) begin
                  state    <= RUN;
                  stop_req <= 1'b0;
                  ack_err  <= 1'b1;
               end
            end
            GATED: begin
               if (wake_cond) begin
                  state     <= WAKE;
                  module_en <= 1'b1;
                  global_en <= 1'b1;
               end
            end
            WAKE: begin
               if (wk_hit) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            default: begin
               state     <= RUN;
               module_en <= 1'b1;
               global_en <= 1'b1;
               stop_req  <= 1'b0;
               ready     <= 1'b1;
            end
         endcase
      end
   end

`ifdef CLK_GATE_CTRL_STAT_EN
   // Count cycles spent with the clock gated; clear beats increment, and the
   // count sticks at all-ones instead of wrapping
   always_ff @(posedge clk_in) begin
      if (rst || stat_clr) begin
         gated_cycles <= '0;
      end else if (!module_en && (gated_cycles != '1)) begin
         gated_cycles <= gated_cycles + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl. A cycle-level reference model
// produces the expected outputs for each driven cycle; they are queued and
// compared after the clock edge. Directed latency checks cover the gating,
// wake, abort, timeout, disable and reset-while-gated cases.
// Define CLK_GATE_CTRL_STAT_EN to also check the gated-cycle statistic.
module tb_clk_gate_ctrl;
   import clk_gate_ctrl_pkg::*;

   localparam int CNT_W    = 8;
   localparam int ACK_TO   = 16;
   localparam int WAKE_CYC = 4;

   logic             clk_in      = 1'b0;
   logic             rst         = 1'b1;
   logic             busy        = 1'b0;
   logic             wake_req    = 1'b0;
   logic             stop_ack    = 1'b0;
   logic             sw_force_on = 1'b0;
   logic             sw_gate_en  = 1'b1;
   logic [CNT_W-1:0] idle_thresh = 8'd3;
   logic             module_en;
   logic             global_en;
   logic             stop_req;
   logic             ready;
   logic             ack_err;
`ifdef CLK_GATE_CTRL_STAT_EN
   logic             stat_clr = 1'b0;
   logic [31:0]      gated_cycles;
`endif

   typedef struct packed {
      logic [4:0]  outs;
      logic [31:0] gcnt;
   } exp_t;

   exp_t sb[$];

   int tests = 0;
   int fails = 0;

   state_t      m_st   = RUN;
   int          m_idle = 0;
   int          m_to   = 0;
   int          m_wk   = 0;
   logic        m_en   = 1'b1;
   logic        m_gen  = 1'b1;
   logic        m_sreq = 1'b0;
   logic        m_rdy  = 1'b1;
   logic        m_aerr = 1'b0;
   logic [31:0] m_gcnt = 32'd0;

   // Free-running always-on clock
   always #5 clk_in = ~clk_in;

   clk_gate_ctrl #(
      .CNT_W    (CNT_W),
      .ACK_TO   (ACK_TO),
      .WAKE_CYC (WAKE_CYC)
   ) dut (
      .clk_in       (clk_in),
      .rst          (rst),
`ifdef CLK_GATE_CTRL_STAT_EN
      .stat_clr     (stat_clr),
      .gated_cycles (gated_cycles),
`endif
      .busy         (busy),
      .wake_req     (wake_req),
      .stop_ack     (stop_ack),
      .sw_force_on  (sw_force_on),
      .sw_gate_en   (sw_gate_en),
      .idle_thresh  (idle_thresh),
      .module_en    (module_en),
      .global_en    (global_en),
      .stop_req     (stop_req),
      .ready        (ready),
      .ack_err      (ack_err)
   );

   function automatic logic [4:0] dutOuts();
      return {module_en, global_en, stop_req, ready, ack_err};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the reference model by one rising edge using the current inputs
   function automatic void modelStep();
      logic inh;
      logic clr;
      clr = rst;
`ifdef CLK_GATE_CTRL_STAT_EN
      clr = clr | stat_clr;
`endif
      if (clr) m_gcnt = 32'd0;
      else if (!m_en && m_gcnt != 32'hFFFF_FFFF) m_gcnt = m_gcnt + 32'd1;

      if (rst) begin
         m_st = RUN; m_idle = 0; m_to = 0; m_wk = 0; m_aerr = 1'b0;
      end else begin
         inh    = busy | wake_req | sw_force_on | !sw_gate_en | (idle_thresh == 0);
         m_aerr = 1'b0;
         case (m_st)
            RUN: if (!inh) begin m_st = IDLE_CNT; m_idle = 1; end
            IDLE_CNT: begin
               if (inh) begin m_st = RUN; m_idle = 0; end
               else if (m_idle == int'(idle_thresh) || m_idle == 255) begin
                  m_st = STOP_REQ; m_to = 0;
               end else m_idle++;
            end
            STOP_REQ: begin
               if (busy | wake_req | sw_force_on) m_st = RUN;
               else if (stop_ack) m_st = GATED;
               else if (m_to == ACK_TO - 1) begin m_st = RUN; m_aerr = 1'b1; end
               else m_to++;
            end
            GATED: if (wake_req | sw_force_on | !sw_gate_en) begin m_st = WAKE; m_wk = 0; end
            WAKE: if (m_wk == WAKE_CYC - 1) m_st = RUN; else m_wk++;
            default: m_st = RUN;
         endcase
      end
      m_en   = (m_st != GATED);
      m_gen  = (m_st != GATED);
      m_sreq = (m_st == STOP_REQ);
      m_rdy  = (m_st == RUN) || (m_st == IDLE_CNT) || (m_st == STOP_REQ);
   endfunction

   // Run n cycles with the current inputs, scoreboarding every cycle
   task automatic applyStimulus(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         modelStep();
         e.outs = {m_en, m_gen, m_sreq, m_rdy, m_aerr};
         e.gcnt = m_gcnt;
         sb.push_back(e);
         @(posedge clk_in);
         #1;
         e = sb.pop_front();
         checkOutput("outs", {27'd0, dutOuts()}, {27'd0, e.outs});
`ifdef CLK_GATE_CTRL_STAT_EN
         checkOutput("gcnt", gated_cycles, e.gcnt);
`endif
      end
   endtask

   task automatic waitStop(input int bound, output int n);
      n = 0;
      while (n < bound) begin
         applyStimulus(1);
         n++;
         if (stop_req === 1'b1) break;
      end
   endtask

   initial begin
      int n;
      int errs;
      logic seen_sreq;
      logic seen_low;

      // Reset state
      rst = 1'b1;
      applyStimulus(2);
      checkOutput("reset", {27'd0, dutOuts()}, 32'b11010);

      // Basic gating with idle_thresh=3 and a late acknowledge
      rst = 1'b0;
      waitStop(40, n);
      checkOutput("stop_lat", n, 4);
      applyStimulus(1);
      stop_ack = 1'b1;
      applyStimulus(1);
      stop_ack = 1'b0;
      checkOutput("gated", {29'd0, module_en, global_en, ready}, 32'd0);
      busy = 1'b1;
      applyStimulus(5);
      checkOutput("busy_ign", {31'd0, module_en}, 32'd0);
      busy = 1'b0;

      // Wake from GATED with a one-cycle request
      wake_req = 1'b1;
      applyStimulus(1);
      wake_req = 1'b0;
      checkOutput("wake_en", {30'd0, module_en, ready}, 32'b10);
      n = 0;
      while (n < 20) begin
         applyStimulus(1);
         n++;
         if (ready === 1'b1) break;
      end
      checkOutput("wake_lat", n, WAKE_CYC);

      // Abort: busy together with stop_ack
      busy = 1'b1;
      applyStimulus(1);
      busy = 1'b0;
      waitStop(40, n);
      checkOutput("stop_lat2", n, 4);
      busy = 1'b1;
      stop_ack = 1'b1;
      applyStimulus(1);
      stop_ack = 1'b0;
      checkOutput("abort", {29'd0, module_en, stop_req, ack_err}, 32'b100);
      applyStimulus(1);

      // Timeout: no acknowledge at all
      busy = 1'b0;
      waitStop(40, n);
      n = 0;
      seen_low = 1'b0;
      while (n < 40) begin
         applyStimulus(1);
         n++;
         if (module_en !== 1'b1) seen_low = 1'b1;
         if (ack_err === 1'b1) break;
      end
      checkOutput("to_lat", n, ACK_TO);
      checkOutput("to_en", {31'd0, seen_low}, 32'd0);
      checkOutput("to_state", {30'd0, stop_req, ready}, 32'b01);
      busy = 1'b1;
      errs = 0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         if (ack_err === 1'b1) errs++;
      end
      checkOutput("ack_once", errs, 0);

      // Disable paths: zero threshold, then software force
      busy = 1'b0;
      idle_thresh = 8'd0;
      seen_sreq = 1'b0;
      seen_low = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1);
         if (stop_req !== 1'b0) seen_sreq = 1'b1;
         if (module_en !== 1'b1) seen_low = 1'b1;
      end
      checkOutput("thr0_sreq", {31'd0, seen_sreq}, 32'd0);
      checkOutput("thr0_en", {31'd0, seen_low}, 32'd0);
      idle_thresh = 8'd3;
      sw_force_on = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1);
         if (stop_req !== 1'b0) seen_sreq = 1'b1;
         if (module_en !== 1'b1) seen_low = 1'b1;
      end
      checkOutput("force_sreq", {31'd0, seen_sreq}, 32'd0);
      checkOutput("force_en", {31'd0, seen_low}, 32'd0);
      sw_force_on = 1'b0;
      busy = 1'b1;
      applyStimulus(1);

      // Smallest threshold: stop request on the second idle cycle
      busy = 1'b0;
      idle_thresh = 8'd1;
      waitStop(40, n);
      checkOutput("thr1_lat", n, 2);
      busy = 1'b1;
      applyStimulus(1);

      // Threshold lowered below the running count: saturation forces the stop
      busy = 1'b0;
      idle_thresh = 8'd5;
      applyStimulus(4);
      idle_thresh = 8'd2;
      waitStop(400, n);
      checkOutput("sat_lat", n, 252);
      busy = 1'b1;
      applyStimulus(1);

      // Reset while gated
      busy = 1'b0;
      idle_thresh = 8'd3;
`ifdef CLK_GATE_CTRL_STAT_EN
      stat_clr = 1'b1;
      applyStimulus(1);
      stat_clr = 1'b0;
      checkOutput("stat_clr", gated_cycles, 32'd0);
`endif
      waitStop(40, n);
      stop_ack = 1'b1;
      applyStimulus(1);
      stop_ack = 1'b0;
      applyStimulus(6);
      checkOutput("pre_rst", {31'd0, module_en}, 32'd0);
`ifdef CLK_GATE_CTRL_STAT_EN
      checkOutput("gated_dur", gated_cycles, 32'd6);
`endif
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      checkOutput("rst_gated", {27'd0, dutOuts()}, 32'b11010);
`ifdef CLK_GATE_CTRL_STAT_EN
      checkOutput("rst_stat", gated_cycles, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
